avalonmm_arbiter: RTL and testbench

AVALONMM_ARBITER -- requirements
Module: avalonmm_arbiter

---
 rtl/avalonmm_arb_pkg.sv | 16 +
 rtl/avalonmm_rd_tracker.sv | 54 +++++
 rtl/avalonmm_arbiter.sv | 110 +++++++++++
 tb/tb_avalonmm_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalonmm_arb_pkg.sv
// Shared types and default constants for the two-master Avalon-MM arbiter.
package avalonmm_arb_pkg;

    typedef enum logic [1:0] {
        OWN0   = 2'd0,
        DRAIN0 = 2'd1,
        OWN1   = 2'd2,
        DRAIN1 = 2'd3
    } arb_state_t;

    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_HOLD_MAX        = 16;
    localparam int DEF_DEFAULT_OWNER   = 0;
    localparam int HOLD_W              = 5;

endpackage

// File: rtl/avalonmm_rd_tracker.sv
// Counts reads accepted but not yet answered, with sticky overflow/underflow flags.
module avalonmm_rd_tracker
    import avalonmm_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_accept,
    input  logic             rd_valid,
    input  logic             err_clear,
    output logic [CNT_W-1:0] count,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic at_max;
    logic at_zero;
    logic ovf_evt;
    logic unf_evt;

    assign at_max  = (count == CNT_MAX);
    assign at_zero = (count == '0);
    assign ovf_evt = rd_accept & ~rd_valid & at_max;
    assign unf_evt = rd_valid & at_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            // A simultaneous accept and response cancel; the count saturates at both ends.
            if (rd_accept && !rd_valid && !at_max)
                count <= count + 1'b1;
            else if (rd_valid && !rd_accept && !at_zero)
                count <= count - 1'b1;

            if (ovf_evt)
                err_overflow <= 1'b1;
            else if (err_clear)
                err_overflow <= 1'b0;

            if (unf_evt)
                err_underflow <= 1'b1;
            else if (err_clear)
                err_underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/avalonmm_arbiter.sv
// Two-master Avalon-MM ownership arbiter: switches the mux select only after the
// bus has drained, with a hold limit so a busy owner cannot starve the other.
module avalonmm_arbiter
    import avalonmm_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int HOLD_MAX        = DEF_HOLD_MAX,
    parameter int DEFAULT_OWNER   = DEF_DEFAULT_OWNER
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 m0_read,
    input  logic                                 m0_write,
    input  logic                                 m1_read,
    input  logic                                 m1_write,
    input  logic                                 bus_read,
    input  logic                                 bus_write,
    input  logic                                 bus_waitrequest,
    input  logic                                 bus_readdatavalid,
    output logic                                 select,
    output logic                                 switching,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    input  logic                                 err_clear,
    output logic                                 err_overflow,
    output logic                                 err_underflow
);

    localparam int               CNT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM   = HOLD_W'(HOLD_MAX);
    localparam arb_state_t       RESET_STATE = (DEFAULT_OWNER == 0) ? OWN0 : OWN1;
    localparam logic             RESET_SEL   = (DEFAULT_OWNER != 0);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold;
    logic              m0_req;
    logic              m1_req;
    logic              cur_req;
    logic              oth_req;
    logic              bus_cmd;
    logic              rd_acc;
    logic              wr_acc;
    logic              stalled;
    logic              drain_done;

    assign m0_req     = m0_read | m0_write;
    assign m1_req     = m1_read | m1_write;
    assign bus_cmd    = bus_read | bus_write;
    assign rd_acc     = bus_read & ~bus_waitrequest;
    assign wr_acc     = bus_write & ~bus_waitrequest;
    assign stalled    = bus_cmd & bus_waitrequest;
    // select always names the owner, in both the OWN and the DRAIN state of that owner.
    assign cur_req    = select ? m1_req : m0_req;
    assign oth_req    = select ? m0_req : m1_req;
    assign drain_done = (outstanding == '0) & ~rd_acc & ~bus_readdatavalid & ~bus_cmd;

    avalonmm_rd_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_rd_tracker (
        .clk           (clk),
        .reset_n       (reset_n),
        .rd_accept     (rd_acc),
        .rd_valid      (bus_readdatavalid),
        .err_clear     (err_clear),
        .count         (outstanding),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET_STATE;
            select    <= RESET_SEL;
            switching <= 1'b0;
            hold      <= '0;
        end else begin
            case (state)
                OWN0, OWN1: begin
                    if (oth_req && (!cur_req || hold == HOLD_LIM) && !stalled) begin
                        state     <= (state == OWN0) ? DRAIN0 : DRAIN1;
                        switching <= 1'b1;
                        hold      <= '0;
                    end else if (!oth_req) begin
                        hold <= '0;
                    end else if ((rd_acc || wr_acc) && hold != HOLD_LIM) begin
                        hold <= hold + 1'b1;
                    end
                end
                DRAIN0, DRAIN1: begin
                    hold <= '0;
                    if (!oth_req) begin
                        state     <= (state == DRAIN0) ? OWN0 : OWN1;
                        switching <= 1'b0;
                    end else if (drain_done) begin
                        state     <= (state == DRAIN0) ? OWN1 : OWN0;
                        select    <= ~select;
                        switching <= 1'b0;
                    end
                end
                default: begin
                    state     <= RESET_STATE;
                    select    <= RESET_SEL;
                    switching <= 1'b0;
                    hold      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalonmm_arbiter.sv
// Scoreboard bench for avalonmm_arbiter with a gated mux model on the bus side.
module tb_avalonmm_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m0_read = 1'b0;
    logic       m0_write = 1'b0;
    logic       m1_read = 1'b0;
    logic       m1_write = 1'b0;
    logic       bus_waitrequest = 1'b0;
    logic       bus_readdatavalid = 1'b0;
    logic       err_clear = 1'b0;
    logic       bus_read;
    logic       bus_write;
    logic       select;
    logic       switching;
    logic [2:0] outstanding;
    logic       err_overflow;
    logic       err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t exp_q[$];

    // The mux forwards only the owner's strobes and blocks everyone while draining.
    assign bus_read  = ~switching & (select ? m1_read : m0_read);
    assign bus_write = ~switching & (select ? m1_write : m0_write);

    avalonmm_arbiter #(
        .MAX_OUTSTANDING (4),
        .HOLD_MAX        (16),
        .DEFAULT_OWNER   (0)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .m0_read           (m0_read),
        .m0_write          (m0_write),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .bus_read          (bus_read),
        .bus_write         (bus_write),
        .bus_waitrequest   (bus_waitrequest),
        .bus_readdatavalid (bus_readdatavalid),
        .select            (select),
        .switching         (switching),
        .outstanding       (outstanding),
        .err_clear         (err_clear),
        .err_overflow      (err_overflow),
        .err_underflow     (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
        end
    endtask

    task automatic exp_push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_pop(input int act);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, act, e.val);
        end
    endtask

    task automatic expect_state(input string tag, input int sel, input int sw, input int outs);
        exp_push({tag, "_select"}, sel);
        exp_push({tag, "_switching"}, sw);
        exp_push({tag, "_outstanding"}, outs);
    endtask

    task automatic compare_state();
        exp_pop(int'(select));
        exp_pop(int'(switching));
        exp_pop(int'(outstanding));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_read = 1'b0;
        m0_write = 1'b0;
        m1_read = 1'b0;
        m1_write = 1'b0;
        bus_waitrequest = 1'b0;
        bus_readdatavalid = 1'b0;
        err_clear = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   last;
        int   ntog;
        logic prev;

        // Reset state
        do_reset();
        expect_state("reset", 0, 0, 0);
        exp_push("reset_ovf", 0);
        exp_push("reset_unf", 0);
        compare_state();
        exp_pop(int'(err_overflow));
        exp_pop(int'(err_underflow));

        // Owner 0 issues three reads, then master 1 asks while reads are in flight
        m0_read = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_state("rd_issue", 0, 0, i);
            step();
            compare_state();
        end
        m0_read = 1'b0;
        m1_read = 1'b1;
        expect_state("drain_enter", 0, 1, 3);
        step();
        compare_state();
        expect_state("drain_wait", 0, 1, 3);
        step();
        compare_state();
        bus_readdatavalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_state("drain_rdv", 0, 1, 2 - i);
            step();
            compare_state();
        end
        bus_readdatavalid = 1'b0;
        expect_state("switch_to1", 1, 0, 0);
        step();
        compare_state();
        m1_read = 1'b0;
        exp_push("no_underflow", 0);
        exp_pop(int'(err_underflow));

        // Owner 1 reaches the hold limit, then a stalled read blocks the switch
        m0_write = 1'b1;
        m1_write = 1'b1;
        repeat (16) step();
        expect_state("hold_fill", 1, 0, 0);
        compare_state();
        m1_write = 1'b0;
        m1_read = 1'b1;
        bus_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_state("stall", 1, 0, 0);
            step();
            compare_state();
        end
        bus_waitrequest = 1'b0;
        expect_state("stall_release", 1, 1, 1);
        step();
        compare_state();
        m1_read = 1'b0;
        expect_state("drain1_hold", 1, 1, 1);
        step();
        compare_state();
        bus_readdatavalid = 1'b1;
        expect_state("drain1_rdv", 1, 1, 0);
        step();
        compare_state();
        bus_readdatavalid = 1'b0;
        expect_state("switch_to0", 0, 0, 0);
        step();
        compare_state();
        m0_write = 1'b0;

        // Both masters write continuously: 16 writes, one more, then the drain cycle
        m0_write = 1'b1;
        m1_write = 1'b1;
        for (int i = 0; i < 3; i++) exp_push("toggle_gap", 18);
        last = 0;
        ntog = 0;
        prev = select;
        for (int c = 0; c < 100 && ntog < 4; c++) begin
            step();
            if (select !== prev) begin
                if (ntog > 0) exp_pop(c - last);
                last = c;
                ntog++;
                prev = select;
            end
        end
        chk("toggle_count", ntog, 4);
        m0_write = 1'b0;
        m1_write = 1'b0;

        // Sticky error flags
        do_reset();
        bus_readdatavalid = 1'b1;
        exp_push("unf_set", 1);
        exp_push("unf_outstanding", 0);
        step();
        exp_pop(int'(err_underflow));
        exp_pop(int'(outstanding));
        bus_readdatavalid = 1'b0;
        exp_push("unf_sticky", 1);
        step();
        exp_pop(int'(err_underflow));
        err_clear = 1'b1;
        exp_push("unf_clear", 0);
        step();
        exp_pop(int'(err_underflow));
        bus_readdatavalid = 1'b1;
        exp_push("unf_set_beats_clear", 1);
        step();
        exp_pop(int'(err_underflow));
        bus_readdatavalid = 1'b0;
        exp_push("unf_clear_again", 0);
        step();
        exp_pop(int'(err_underflow));
        err_clear = 1'b0;
        m0_read = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_push("ovf_outstanding", (i > 4) ? 4 : i);
            exp_push("ovf_flag", (i == 5) ? 1 : 0);
            step();
            exp_pop(int'(outstanding));
            exp_pop(int'(err_overflow));
        end
        m0_read = 1'b0;
        exp_push("ovf_sticky", 1);
        step();
        exp_pop(int'(err_overflow));
        err_clear = 1'b1;
        exp_push("ovf_clear", 0);
        step();
        exp_pop(int'(err_overflow));
        err_clear = 1'b0;

        // Other master withdraws during drain: back to the same owner
        do_reset();
        m1_read = 1'b1;
        expect_state("abort_drain", 0, 1, 0);
        step();
        compare_state();
        m1_read = 1'b0;
        expect_state("abort_own0", 0, 0, 0);
        step();
        compare_state();
        expect_state("abort_stay", 0, 0, 0);
        step();
        compare_state();

        // Asynchronous reset in the middle of a drain with reads in flight
        do_reset();
        m0_read = 1'b1;
        step();
        step();
        m0_read = 1'b0;
        m1_read = 1'b1;
        expect_state("pre_reset_drain", 0, 1, 2);
        step();
        compare_state();
        reset_n = 1'b0;
        #1;
        expect_state("async_reset", 0, 0, 0);
        compare_state();
        step();
        reset_n = 1'b1;
        m1_read = 1'b0;
        step();
        bus_readdatavalid = 1'b1;
        exp_push("late_rsp_unf", 1);
        exp_push("late_rsp_outstanding", 0);
        step();
        exp_pop(int'(err_underflow));
        exp_pop(int'(outstanding));
        bus_readdatavalid = 1'b0;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
